// File: rtl/input_conditioner.sv
// Per-channel synchronizer, debouncer and edge detector for buttons/switches.
// Optional macro INPUT_CONDITIONER_TOGGLE_EN adds a press-to-toggle flop per channel.
module input_conditioner #(
    parameter int CHANNELS        = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] toggle
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CW-1:0]          count_reg;
            logic                   level_reg;
            logic                   rise_reg;
            logic                   fall_reg;
            logic                   sync_s;

            assign sync_s = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
                end
            end

            // Any cycle where the synchronized input agrees with the accepted
            // level restarts the count, so only an unbroken run is accepted.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg <= '0;
                    level_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else if (sync_s == level_reg) begin
                    count_reg <= '0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else if (count_reg == LAST_COUNT) begin
                    count_reg <= '0;
                    level_reg <= sync_s;
                    rise_reg  <= sync_s;
                    fall_reg  <= ~sync_s;
                end else begin
                    count_reg <= count_reg + CW'(1);
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end
            end

            assign level[gi] = level_reg;
            assign rise[gi]  = rise_reg;
            assign fall[gi]  = fall_reg;

`ifdef INPUT_CONDITIONER_TOGGLE_EN
            logic toggle_reg;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    toggle_reg <= 1'b0;
                end else if (rise_reg) begin
                    toggle_reg <= ~toggle_reg;
                end
            end

            assign toggle[gi] = toggle_reg;
`else
            assign toggle[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a window-based reference model.
module tb_input_conditioner;

    localparam int CHANNELS        = 5;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int HD              = SYNC_STAGES + DEBOUNCE_CYCLES - 1;

    logic                clock   = 1'b0;
    logic                reset_n = 1'b0;
    logic [CHANNELS-1:0] raw_in  = '0;
    logic [CHANNELS-1:0] level, rise, fall, toggle;

    int n_checks = 0;
    int n_fail   = 0;

    input_conditioner #(
        .CHANNELS       (CHANNELS),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .raw_in (raw_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .toggle (toggle)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the level takes value v once the raw samples seen by
    // the last DEBOUNCE_CYCLES edges (delayed by the synchronizer) are all v.
    logic [CHANNELS-1:0] hist [HD];
    logic [CHANNELS-1:0] m_level  = '0;
    logic [CHANNELS-1:0] m_rise   = '0;
    logic [CHANNELS-1:0] m_fall   = '0;
    logic [CHANNELS-1:0] m_toggle = '0;
    logic [CHANNELS-1:0] m_all1, m_all0, m_next;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < HD; k++) hist[k] = '0;
            m_level  = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_toggle = '0;
        end else begin
            m_all1 = '1;
            m_all0 = '1;
            for (int k = SYNC_STAGES - 1; k < HD; k++) begin
                m_all1 &= hist[k];
                m_all0 &= ~hist[k];
            end
            m_next = (m_level | m_all1) & ~m_all0;
`ifdef INPUT_CONDITIONER_TOGGLE_EN
            m_toggle = m_toggle ^ m_rise;
`endif
            m_rise  = m_next & ~m_level;
            m_fall  = ~m_next & m_level;
            m_level = m_next;
            for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = raw_in;
        end
    end

    always @(negedge clock) begin
        chk("level_vs_model",  level,  m_level);
        chk("rise_vs_model",   rise,   m_rise);
        chk("fall_vs_model",   fall,   m_fall);
        chk("toggle_vs_model", toggle, m_toggle);
        chk("rise_fall_excl",  rise & fall, '0);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    logic seq [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int   n_rise2;
    int   rise2_at;
    logic exp_tog;

    initial begin
        // Reset state
        tick(2);
        chk("reset_level", level, 5'b00000);
        chk("reset_rise",  rise,  5'b00000);
        chk("reset_fall",  fall,  5'b00000);
        chk("reset_toggle", toggle, 5'b00000);
        reset_n = 1'b1;
        tick(2);

        // Clean change on channel 0: six edges of latency
        raw_in = 5'b00001;
        tick(5);
        chk("ch0_level_before", level, 5'b00000);
        chk("ch0_rise_before",  rise,  5'b00000);
        tick();
        chk("ch0_level_at6", level, 5'b00001);
        chk("ch0_rise_at6",  rise,  5'b00001);
        tick();
        chk("ch0_rise_after", rise,  5'b00000);
        chk("ch0_level_hold", level, 5'b00001);

        // Three-cycle glitch on channel 1 is rejected
        raw_in[1] = 1'b1;
        for (int t = 0; t < 11; t++) begin
            if (t == 3) raw_in[1] = 1'b0;
            tick();
            chk("ch1_glitch", {level[1], rise[1], fall[1]}, 3'b000);
        end

        // Bouncing channel 2 is accepted only after the final stable run
        n_rise2  = 0;
        rise2_at = 0;
        for (int t = 0; t < 14; t++) begin
            raw_in[2] = (t < 9) ? seq[t] : 1'b1;
            tick();
            if (rise[2]) begin
                n_rise2++;
                rise2_at = t + 1;
            end
        end
        chk("ch2_rise_count", n_rise2, 1);
        chk("ch2_rise_edge",  rise2_at, 11);
        chk("ch2_level",      level[2], 1'b1);

        // All channels together
        raw_in = 5'b00000;
        tick(8);
        chk("all_cleared", level, 5'b00000);
        raw_in = 5'b11111;
        tick(5);
        chk("all_level_before", level, 5'b00000);
        tick();
        chk("all_level_at6", level, 5'b11111);
        chk("all_rise_at6",  rise,  5'b11111);
        tick();
        chk("all_rise_after", rise, 5'b00000);
        raw_in = 5'b00000;
        tick(6);
        chk("all_fall_at6",  fall,  5'b11111);
        chk("all_level_low", level, 5'b00000);

        // Reset in the middle of a count on channel 3
        raw_in = 5'b00001;
        tick(8);
        chk("pre_reset_level", level, 5'b00001);
        raw_in = 5'b01001;
        tick(4);
        #2 reset_n = 1'b0;
        #1;
        chk("async_level", level, 5'b00000);
        chk("async_rise",  rise,  5'b00000);
        chk("async_fall",  fall,  5'b00000);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        chk("post_reset_rise_before", rise, 5'b00000);
        tick();
        chk("post_reset_rise_at6", rise,  5'b01001);
        chk("post_reset_level",    level, 5'b01001);

        // Three presses on channel 4
        for (int p = 0; p < 3; p++) begin
            raw_in[4] = 1'b1;
            tick(8);
`ifdef INPUT_CONDITIONER_TOGGLE_EN
            exp_tog = (p % 2 == 0);
`else
            exp_tog = 1'b0;
`endif
            chk("toggle4", toggle[4], exp_tog);
            raw_in[4] = 1'b0;
            tick(8);
        end
`ifndef INPUT_CONDITIONER_TOGGLE_EN
        chk("toggle_all_zero", toggle, 5'b00000);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
